// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with a programmable prescaler,
// synchronous load, wrap-or-saturate boundaries, a one-cycle terminal pulse
// and a sticky overflow flag.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - asynchronous active-low reset
//   enable     - counting enable; prescaler and counter frozen when low
//   up_down    - count direction (1 = up, 0 = down)
//   load       - synchronous load strobe (wins over ticks, ignores enable)
//   load_value - value loaded, clamped to COUNTER_MAX
//   prescale   - counter steps once every prescale+1 enabled cycles
//   clear_ovf  - clears the sticky overflow flag
//   counter    - registered count value
//   terminal   - registered pulse, high for the cycle after a boundary event
//   overflow   - registered sticky boundary flag
module mod_counter #(
    parameter int unsigned COUNTER_WIDTH  = 8,
    parameter int unsigned COUNTER_MAX    = 255,
    parameter int unsigned PRESCALE_WIDTH = 4,
    parameter bit          SATURATE       = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      up_down,
    input  logic                      load,
    input  logic [COUNTER_WIDTH-1:0]  load_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      clear_ovf,
    output logic [COUNTER_WIDTH-1:0]  counter,
    output logic                      terminal,
    output logic                      overflow
);

    localparam logic [COUNTER_WIDTH-1:0] MAX_V = COUNTER_WIDTH'(COUNTER_MAX);

    logic [COUNTER_WIDTH-1:0]  r_counter;
    logic [PRESCALE_WIDTH-1:0] r_pcnt;
    logic                      r_terminal;
    logic                      r_overflow;

    logic                      w_tick;
    logic                      w_at_max;
    logic                      w_at_zero;
    logic                      w_boundary;
    logic [COUNTER_WIDTH-1:0]  w_load_val;
    logic [COUNTER_WIDTH-1:0]  w_step;

    // Tick, boundary detection and next count value
    always_comb begin
        w_tick     = 1'b0;
        w_at_max   = 1'b0;
        w_at_zero  = 1'b0;
        w_boundary = 1'b0;
        w_load_val = load_value;
        w_step     = r_counter;

        // >= compare so a prescale lowered below pcnt ticks right away
        w_tick    = enable && (r_pcnt >= prescale);
        w_at_max  = (r_counter == MAX_V);
        w_at_zero = (r_counter == '0);
        // a load on the same edge suppresses the boundary event
        w_boundary = w_tick && !load && (up_down ? w_at_max : w_at_zero);

        if (load_value > MAX_V) begin
            w_load_val = MAX_V;
        end

        if (up_down) begin
            if (w_at_max) begin
                w_step = SATURATE ? MAX_V : '0;
            end else begin
                w_step = r_counter + COUNTER_WIDTH'(1);
            end
        end else begin
            if (w_at_zero) begin
                w_step = SATURATE ? '0 : MAX_V;
            end else begin
                w_step = r_counter - COUNTER_WIDTH'(1);
            end
        end
    end

    // State registers: load > tick > hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_counter  <= '0;
            r_pcnt     <= '0;
            r_terminal <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (load) begin
                r_counter  <= w_load_val;
                r_pcnt     <= '0;
                r_terminal <= 1'b0;
            end else if (w_tick) begin
                r_counter  <= w_step;
                r_pcnt     <= '0;
                r_terminal <= w_boundary;
            end else begin
                if (enable) begin
                    r_pcnt <= r_pcnt + PRESCALE_WIDTH'(1);
                end
                r_terminal <= 1'b0;
            end

            // a boundary event beats a simultaneous clear
            if (w_boundary) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign counter  = r_counter;
    assign terminal = r_terminal;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_mod_counter.sv
// Directed testbench for mod_counter using three parameterisations:
//   A: 3-bit, MAX=7, wrap       B: 8-bit, MAX=100, wrap
//   C: 3-bit, MAX=5, saturate
module tb_mod_counter;

    logic clk;
    logic reset;

    logic       a_enable, a_up, a_load, a_clr;
    logic [2:0] a_lv;
    logic [3:0] a_pre;
    logic [2:0] a_cnt;
    logic       a_term, a_ovf;

    logic       b_enable, b_up, b_load, b_clr;
    logic [7:0] b_lv;
    logic [3:0] b_pre;
    logic [7:0] b_cnt;
    logic       b_term, b_ovf;

    logic       c_enable, c_up, c_load, c_clr;
    logic [2:0] c_lv;
    logic [1:0] c_pre;
    logic [2:0] c_cnt;
    logic       c_term, c_ovf;

    int checks;
    int errors;

    mod_counter #(.COUNTER_WIDTH(3), .COUNTER_MAX(7), .PRESCALE_WIDTH(4), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(reset), .enable(a_enable), .up_down(a_up), .load(a_load),
        .load_value(a_lv), .prescale(a_pre), .clear_ovf(a_clr),
        .counter(a_cnt), .terminal(a_term), .overflow(a_ovf)
    );

    mod_counter #(.COUNTER_WIDTH(8), .COUNTER_MAX(100), .PRESCALE_WIDTH(4), .SATURATE(1'b0)) u_b (
        .clk(clk), .reset(reset), .enable(b_enable), .up_down(b_up), .load(b_load),
        .load_value(b_lv), .prescale(b_pre), .clear_ovf(b_clr),
        .counter(b_cnt), .terminal(b_term), .overflow(b_ovf)
    );

    mod_counter #(.COUNTER_WIDTH(3), .COUNTER_MAX(5), .PRESCALE_WIDTH(2), .SATURATE(1'b1)) u_c (
        .clk(clk), .reset(reset), .enable(c_enable), .up_down(c_up), .load(c_load),
        .load_value(c_lv), .prescale(c_pre), .clear_ovf(c_clr),
        .counter(c_cnt), .terminal(c_term), .overflow(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        a_enable = 1'b0; a_up = 1'b1; a_load = 1'b0; a_clr = 1'b0; a_lv = '0; a_pre = '0;
        b_enable = 1'b0; b_up = 1'b1; b_load = 1'b0; b_clr = 1'b0; b_lv = '0; b_pre = '0;
        c_enable = 1'b0; c_up = 1'b1; c_load = 1'b0; c_clr = 1'b0; c_lv = '0; c_pre = '0;

        // asynchronous reset before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_a_term", 32'(a_term), 0);
        chk("rst_a_ovf", 32'(a_ovf), 0);
        chk("rst_b_cnt", 32'(b_cnt), 0);
        chk("rst_c_cnt", 32'(c_cnt), 0);
        chk("rst_c_ovf", 32'(c_ovf), 0);
        step(1);
        reset = 1'b1;

        // A: prescale=0 up count 1..7, then wrap to 0
        a_enable = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk($sformatf("a_up_%0d", i), 32'(a_cnt), 32'(i));
            chk($sformatf("a_up_term_%0d", i), 32'(a_term), 0);
        end
        chk("a_pre_wrap_ovf", 32'(a_ovf), 0);
        step(1);
        chk("a_wrap_cnt", 32'(a_cnt), 0);
        chk("a_wrap_term", 32'(a_term), 1);
        chk("a_wrap_ovf", 32'(a_ovf), 1);
        step(1);
        chk("a_after_cnt", 32'(a_cnt), 1);
        chk("a_after_term", 32'(a_term), 0);
        chk("a_sticky_ovf", 32'(a_ovf), 1);
        a_clr = 1'b1;
        step(1);
        chk("a_clr_ovf", 32'(a_ovf), 0);
        chk("a_clr_cnt", 32'(a_cnt), 2);
        a_clr = 1'b0;
        a_enable = 1'b0;

        // B: prescale=3 -> one step per 4 enabled cycles
        b_pre = 4'd3;
        b_enable = 1'b1;
        step(3);
        chk("b_pre3_hold", 32'(b_cnt), 0);
        step(1);
        chk("b_pre3_tick", 32'(b_cnt), 1);
        step(2);
        chk("b_mid_period", 32'(b_cnt), 1);
        b_enable = 1'b0;
        step(2);
        chk("b_frozen_cnt", 32'(b_cnt), 1);
        chk("b_frozen_term", 32'(b_term), 0);
        b_enable = 1'b1;
        step(1);
        chk("b_stretch_hold", 32'(b_cnt), 1);
        step(1);
        chk("b_stretch_tick", 32'(b_cnt), 2);

        // B: clamped load on the same edge as a tick
        step(2);
        chk("b_pre_load", 32'(b_cnt), 2);
        b_pre = 4'd2;
        b_load = 1'b1;
        b_lv = 8'd200;
        step(1);
        chk("b_load_clamp", 32'(b_cnt), 100);
        chk("b_load_term", 32'(b_term), 0);
        chk("b_load_ovf", 32'(b_ovf), 0);
        b_load = 1'b0;
        step(2);
        chk("b_pcnt_cleared", 32'(b_cnt), 100);
        step(1);
        chk("b_wrap_cnt", 32'(b_cnt), 0);
        chk("b_wrap_term", 32'(b_term), 1);
        chk("b_wrap_ovf", 32'(b_ovf), 1);

        // B: down wrap with a simultaneous clear_ovf
        b_pre = 4'd0;
        b_up = 1'b0;
        b_clr = 1'b1;
        step(1);
        chk("b_dn_wrap_cnt", 32'(b_cnt), 100);
        chk("b_dn_wrap_term", 32'(b_term), 1);
        chk("b_clr_vs_event", 32'(b_ovf), 1);
        b_enable = 1'b0;
        step(1);
        chk("b_clr_alone", 32'(b_ovf), 0);
        chk("b_clr_term", 32'(b_term), 0);
        chk("b_clr_cnt", 32'(b_cnt), 100);
        b_clr = 1'b0;
        b_enable = 1'b1;
        step(1);
        chk("b_dec", 32'(b_cnt), 99);
        b_up = 1'b1;
        step(1);
        chk("b_dir_change", 32'(b_cnt), 100);
        step(1);
        chk("b_wrap2_cnt", 32'(b_cnt), 0);
        chk("b_wrap2_ovf", 32'(b_ovf), 1);
        b_enable = 1'b0;

        // C: saturating down count from 1
        c_enable = 1'b1;
        c_up = 1'b0;
        c_load = 1'b1;
        c_lv = 3'd1;
        step(1);
        chk("c_load1", 32'(c_cnt), 1);
        chk("c_load1_term", 32'(c_term), 0);
        c_load = 1'b0;
        step(1);
        chk("c_dn0", 32'(c_cnt), 0);
        chk("c_dn0_term", 32'(c_term), 0);
        chk("c_dn0_ovf", 32'(c_ovf), 0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk($sformatf("c_sat_cnt_%0d", i), 32'(c_cnt), 0);
            chk($sformatf("c_sat_term_%0d", i), 32'(c_term), 1);
        end
        chk("c_sat_ovf", 32'(c_ovf), 1);
        c_enable = 1'b0;
        step(1);
        chk("c_dis_term", 32'(c_term), 0);
        chk("c_dis_cnt", 32'(c_cnt), 0);
        c_load = 1'b1;
        c_lv = 3'd3;
        step(1);
        chk("c_load_no_en", 32'(c_cnt), 3);
        c_lv = 3'd7;
        step(1);
        chk("c_load_clamp", 32'(c_cnt), 5);
        c_load = 1'b0;
        c_enable = 1'b1;
        c_up = 1'b1;
        step(1);
        chk("c_sat_up_cnt", 32'(c_cnt), 5);
        chk("c_sat_up_term", 32'(c_term), 1);
        c_up = 1'b0;
        step(1);
        chk("c_dn_from_max", 32'(c_cnt), 4);
        chk("c_dn_from_max_term", 32'(c_term), 0);
        c_enable = 1'b0;

        // B: asynchronous reset mid-count (counter=5, pcnt=2)
        b_load = 1'b1;
        b_lv = 8'd5;
        step(1);
        b_load = 1'b0;
        b_pre = 4'd3;
        b_enable = 1'b1;
        step(2);
        chk("b_pre_reset_cnt", 32'(b_cnt), 5);
        #2 reset = 1'b0;
        #1;
        chk("b_async_cnt", 32'(b_cnt), 0);
        chk("b_async_term", 32'(b_term), 0);
        chk("b_async_ovf", 32'(b_ovf), 0);
        chk("c_async_ovf", 32'(c_ovf), 0);
        chk("c_async_cnt", 32'(c_cnt), 0);
        #2 reset = 1'b1;
        step(3);
        chk("b_post_reset_hold", 32'(b_cnt), 0);
        step(1);
        chk("b_post_reset_tick", 32'(b_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
